// File: rtl/apb_arbiter_if.sv
// APB bus bundle between the two-requester arbiter (master side) and an APB completer.
interface apb_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] PADDR;
   logic              PWRITE;
   logic [DATA_W-1:0] PWDATA;
   logic              PSEL;
   logic              PENABLE;
   logic [DATA_W-1:0] PRDATA;
   logic              PREADY;
   logic              PSLVERR;

   modport master (
      output PADDR, PWRITE, PWDATA, PSEL, PENABLE,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PADDR, PWRITE, PWDATA, PSEL, PENABLE,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_arbiter.sv
// Two-requester round-robin arbiter driving a single APB master port with a
// bounded wait-state timeout; every output is registered.
module apb_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              req0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic              write0,
   input  logic              write1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              done0,
   output logic              done1,
   output logic              err0,
   output logic              err1,
   output logic [DATA_W-1:0] rdata,
   apb_arbiter_if.master     apb
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t            state, state_n;
   logic [7:0]        wait_cnt, wait_cnt_n;
   logic              owner, last;
   logic              elig0, elig1, grant_any, grant1;
   logic              finish, finish_ok, err_n;
   logic [ADDR_W-1:0] paddr;
   logic              pwrite;
   logic [DATA_W-1:0] pwdata;
   logic              psel, penable;

   assign apb.PADDR   = paddr;
   assign apb.PWRITE  = pwrite;
   assign apb.PWDATA  = pwdata;
   assign apb.PSEL    = psel;
   assign apb.PENABLE = penable;

   always_ff @(posedge PCLK) begin
      if (PRESET) state <= IDLE;
      else        state <= state_n;
   end

   // A requester whose done is high this cycle is not eligible, letting the other one in.
   always_comb begin
      elig0     = req0 & ~done0;
      elig1     = req1 & ~done1;
      grant_any = elig0 | elig1;
      grant1    = elig1 & (~elig0 | ~last);
      state_n   = state;
      case (state)
         IDLE:    if (grant_any) state_n = SETUP;
         SETUP:   state_n = ACCESS;
         ACCESS:  if (apb.PREADY || (wait_cnt == WAIT_LAST)) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Ready wins over timeout: a timed-out finish is one that ends with PREADY low.
   always_comb begin
      finish     = (state == ACCESS) && (state_n == IDLE);
      finish_ok  = finish & apb.PREADY;
      err_n      = apb.PREADY ? apb.PSLVERR : 1'b1;
      wait_cnt_n = wait_cnt;
      if (state == SETUP)
         wait_cnt_n = '0;
      else if ((state == ACCESS) && !apb.PREADY)
         wait_cnt_n = wait_cnt + 8'd1;
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         psel     <= 1'b0;
         penable  <= 1'b0;
         paddr    <= '0;
         pwrite   <= 1'b0;
         pwdata   <= '0;
         rdata    <= '0;
         done0    <= 1'b0;
         done1    <= 1'b0;
         err0     <= 1'b0;
         err1     <= 1'b0;
         wait_cnt <= '0;
         owner    <= 1'b0;
         last     <= 1'b1;
      end else begin
         psel     <= (state_n != IDLE);
         penable  <= (state_n == ACCESS);
         done0    <= finish & ~owner;
         done1    <= finish & owner;
         err0     <= finish & ~owner & err_n;
         err1     <= finish & owner & err_n;
         wait_cnt <= wait_cnt_n;
         if ((state == IDLE) && grant_any) begin
            owner  <= grant1;
            last   <= grant1;
            paddr  <= grant1 ? addr1  : addr0;
            pwrite <= grant1 ? write1 : write0;
            pwdata <= grant1 ? wdata1 : wdata0;
         end
         if (finish_ok && !pwrite)
            rdata <= apb.PRDATA;
      end
   end

endmodule

// File: tb/tb_apb_arbiter.sv
// Directed scoreboard bench for apb_arbiter: the bench plays the APB completer
// and checks grants, latency, wait states, timeout, errors and reset abort.
module tb_apb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, req1, write0, write1;
   logic [31:0] addr0, addr1, wdata0, wdata1;
   logic        done0, done1, err0, err1;
   logic [31:0] rdata;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        idx;
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] rd;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] exp_rd;

   apb_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   apb_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
      .PCLK(clk), .PRESET(rst),
      .req0(req0), .req1(req1),
      .addr0(addr0), .addr1(addr1),
      .write0(write0), .write1(write1),
      .wdata0(wdata0), .wdata1(wdata1),
      .done0(done0), .done1(done1),
      .err0(err0), .err1(err1),
      .rdata(rdata),
      .apb(bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed hang expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic idx, input logic [31:0] a, input logic w,
                       input logic [31:0] d, input logic e, input logic [31:0] r);
      exp_t x;
      x.idx = idx; x.addr = a; x.wr = w; x.wdata = d; x.err = e; x.rd = r;
      sb.push_back(x);
   endtask

   // Act as the completer for one transfer: insert `waits` PREADY-low ACCESS cycles
   // then answer, and check the completion against the scoreboard head.
   task automatic serve(input int waits, input logic [31:0] prd, input logic serr,
                        input int exp_lat);
      int   lat = 0;
      int   acc = 0;
      logic fin = 1'b0;
      exp_t e;
      while (!fin && lat < 40) begin
         step();
         lat++;
         if (done0 | done1) begin
            fin = 1'b1;
            chk("done_exclusive", 64'(done0 & done1), 0);
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else begin
               e = sb.pop_front();
               chk("done_index", 64'(done1), 64'(e.idx));
               chk("err", 64'(done1 ? err1 : err0), 64'(e.err));
               chk("rdata", 64'(rdata), 64'(e.rd));
               chk("bus_idle_at_done", 64'({bus.PSEL, bus.PENABLE}), 0);
               chk("latency", 64'(lat), 64'(exp_lat));
            end
            bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
         end else if (bus.PSEL && !bus.PENABLE) begin
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else begin
               chk("setup_paddr", 64'(bus.PADDR), 64'(sb[0].addr));
               chk("setup_pwrite", 64'(bus.PWRITE), 64'(sb[0].wr));
               chk("setup_pwdata", 64'(bus.PWDATA), 64'(sb[0].wdata));
            end
            // Junk outside ACCESS that must not influence the transfer.
            bus.PREADY = 1'b1; bus.PSLVERR = 1'b1; bus.PRDATA = 32'hBAD0_BAD0;
         end else if (bus.PSEL && bus.PENABLE) begin
            if (sb.size() != 0) chk("access_paddr_hold", 64'(bus.PADDR), 64'(sb[0].addr));
            if (acc < waits) begin
               bus.PREADY = 1'b0; bus.PSLVERR = 1'b1; acc++;
            end else begin
               bus.PREADY = 1'b1; bus.PSLVERR = serr; bus.PRDATA = prd;
            end
         end else begin
            bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
         end
      end
      if (!fin) chk("done_wait_expired", 0, 1);
   endtask

   initial begin
      rst = 1'b1;
      req0 = 0; req1 = 0; write0 = 0; write1 = 0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      bus.PREADY = 0; bus.PSLVERR = 0; bus.PRDATA = '0;
      exp_rd = '0;
      step();
      step();
      chk("rst_psel", 64'(bus.PSEL), 0);
      chk("rst_penable", 64'(bus.PENABLE), 0);
      chk("rst_paddr", 64'(bus.PADDR), 0);
      chk("rst_pwrite", 64'(bus.PWRITE), 0);
      chk("rst_pwdata", 64'(bus.PWDATA), 0);
      chk("rst_rdata", 64'(rdata), 0);
      chk("rst_done", 64'({done0, done1, err0, err1}), 0);
      rst = 1'b0;

      // Zero-wait write from requester 0.
      req0 = 1; addr0 = 32'h04; write0 = 1; wdata0 = 32'hA5A5_0001;
      push(0, 32'h04, 1, 32'hA5A5_0001, 0, exp_rd);
      serve(0, 32'h0, 0, 3);
      req0 = 0;

      // Read from requester 1 with three wait states (last one at the timeout boundary).
      req1 = 1; addr1 = 32'h10; write1 = 0; wdata1 = 32'h1111_2222;
      exp_rd = 32'hDEAD_BEEF;
      push(1, 32'h10, 0, 32'h1111_2222, 0, exp_rd);
      serve(3, 32'hDEAD_BEEF, 0, 6);
      req1 = 0;

      // Timeout: PREADY never rises, rdata must survive.
      req0 = 1; addr0 = 32'h20; write0 = 0;
      push(0, 32'h20, 0, 32'hA5A5_0001, 1, exp_rd);
      serve(99, 32'h1234_5678, 0, 6);
      req0 = 0;

      // Slave error on a write, then a clean write.
      req1 = 1; addr1 = 32'h30; write1 = 1; wdata1 = 32'h5555_AAAA;
      push(1, 32'h30, 1, 32'h5555_AAAA, 1, exp_rd);
      serve(0, 32'h0, 1, 3);
      req1 = 0;
      req0 = 1; addr0 = 32'h40; write0 = 1; wdata0 = 32'h0BAD_F00D;
      push(0, 32'h40, 1, 32'h0BAD_F00D, 0, exp_rd);
      serve(0, 32'h0, 0, 3);
      req0 = 0;

      // Reset during ACCESS aborts silently.
      req0 = 1; addr0 = 32'h50; write0 = 1; wdata0 = 32'h5050_5050;
      for (int i = 0; i < 10 && !(bus.PSEL && bus.PENABLE); i++) begin
         step();
         bus.PREADY = 1'b0;
      end
      chk("reached_access", 64'({bus.PSEL, bus.PENABLE}), 64'(2'b11));
      rst = 1'b1;
      req1 = 1; addr1 = 32'h60; write1 = 0; wdata1 = 32'h6060_6060;
      step();
      chk("rst_abort_bus", 64'({bus.PSEL, bus.PENABLE}), 0);
      chk("rst_abort_done", 64'({done0, done1}), 0);
      chk("rst_abort_rdata", 64'(rdata), 0);
      rst = 1'b0;
      exp_rd = '0;
      sb.delete();

      // Tie after reset: requester 0 first, then strict alternation.
      push(0, 32'h50, 1, 32'h5050_5050, 0, exp_rd);
      push(1, 32'h60, 0, 32'h6060_6060, 0, 32'hC0DE_0001);
      push(0, 32'h50, 1, 32'h5050_5050, 0, 32'hC0DE_0001);
      push(1, 32'h60, 0, 32'h6060_6060, 0, 32'hC0DE_0003);
      serve(0, 32'hC0DE_0000, 0, 3);
      serve(0, 32'hC0DE_0001, 0, 3);
      serve(0, 32'hC0DE_0002, 0, 3);
      serve(0, 32'hC0DE_0003, 0, 3);
      req0 = 0; req1 = 0;
      step();
      step();
      chk("final_idle", 64'({bus.PSEL, bus.PENABLE, done0, done1}), 0);
      chk("sb_drained", 64'(sb.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
